mlp_engine: RTL and testbench
=============================

MLP_ENGINE -- requirements
Module: mlp_engine

Interface
REQ-001 Parameter DW, 16, signed data/weight width (fixed-point Q(DW-FRAC).FRAC).
REQ-002 Parameter FRAC, 8, fractional bits.
REQ-003 Parameter H, 16, hidden-layer width (topology 1 -> H -> H -> 1).
REQ-004 Parameter AW, 40, accumulator width; SHALL be >= 2*DW + clog2(H+1).
REQ-005 Derived DEPTH = H*H + 4*H + 1 parameter words; LAT = H*H + 4*H + 2 cycles.
REQ-006 clk  in  1  single clock, all logic on posedge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 wr_en  in  1  parameter write strobe.
REQ-009 wr_addr  in  clog2(DEPTH)  parameter word address.
REQ-010 wr_data  in  DW  parameter word.
REQ-011 start  in  1  inference request.
REQ-012 in_data  in  DW  signed input sample.
REQ-013 busy  out  1  inference in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 out_data  out  DW  signed result, held until next completion or reset.

Function
REQ-016 Address map: [0,H) L1 weights; [H,2H) L1 bias; [2H,2H+H*H) L2 weights, row-major, addr = 2H + n*H + k; next H L2 bias; next H L3 weights; last word output bias.
REQ-017 Writes SHALL take effect when wr_en=1, busy=0 and wr_addr<DEPTH; otherwise ignored.
REQ-018 FSM states IDLE, L1, L2, L3, DONE; start accepted only in IDLE, which latches in_data, sets busy and enters L1.
REQ-019 start in any other state SHALL be ignored, with no queuing.
REQ-020 Each neuron with fan-in K SHALL take K+1 cycles: 1 cycle acc = sign-extended bias << FRAC, then K cycles acc += w*x, one product per cycle.
REQ-021 Fan-in K is 1 for L1 and H for L2 and L3; neurons are processed in ascending index order; L1->L2->L3 advance with no idle cycles.
REQ-022 Requantise: arithmetic shift right by FRAC (floor), then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-023 L1/L2 results SHALL pass through ReLU (negative -> 0) after saturation and be stored in an H-entry activation buffer; the L3 result has no ReLU.
REQ-024 The accumulator SHALL wrap modulo 2^AW, with no overflow flag.
REQ-025 Final result registered to out_data on entry to DONE; done=1 for exactly the DONE cycle; DONE -> IDLE unconditionally, busy=0 in DONE.
REQ-026 done SHALL occur exactly LAT cycles after the start-accept edge (H=4 -> 34; H=16 -> 322).
REQ-027 start asserted during the DONE cycle SHALL be ignored; the earliest new accept is the following cycle.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state IDLE, busy 0, done 0, out_data 0, and clear all counters and the accumulator.
REQ-029 Reset mid-inference SHALL abort with no done pulse.
REQ-030 The parameter memory and activation buffer SHALL NOT be reset; parameter contents SHALL persist across reset.

Structure
REQ-031 Package nn_pkg SHALL hold the state enum, the address-offset functions (in terms of H), and the saturate/requantise function.
REQ-032 Sub-module mlp_mac SHALL implement the multiply, accumulate, bias-load and requantise datapath; the FSM, counters and memories stay in mlp_engine.

Verification (H=4, DW=16, FRAC=8, AW=40)
REQ-033 All params 0 except out bias=0x0100; start, in=0x1234 -> out_data=0x0100, done 34 cycles after accept.
REQ-034 L1w[0]=L2w[0][0]=L3w[0]=0x0100, others 0; in=0x0280 -> out 0x0280; in=0xFD80 (-2.5) -> out 0x0000 (ReLU).
REQ-035 All weights 0x7FFF, biases 0, in=0x7FFF -> out 0x7FFF; all L3 weights 0x8000 with same hidden -> out 0x8000 (saturation).
REQ-036 Identity setup from REQ-034, in=0x0280; during busy pulse start with in=0x0500 and write L3w[0]=0 -> single done, out 0x0280, L3w[0] unchanged on rerun.
REQ-037 rst_n low for 1 cycle 10 cycles into L2 -> busy/done/out_data 0 next cycle, no done; restart -> out 0x0280 at accept+34.
REQ-038 Start held high continuously -> accepts 36 cycles apart (34 + DONE + IDLE accept), done every 36 cycles, identical out_data.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared types and helpers for the 1->H->H->1 MLP: FSM states, parameter-memory map, requantiser.
// Pure package, no logic of its own.
package nn_pkg;

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_L3, S_DONE} state_t;

  function automatic int l1_b_off(input int h);
    return h;
  endfunction

  function automatic int l2_w_off(input int h);
    return 2 * h;
  endfunction

  function automatic int l2_b_off(input int h);
    return 2 * h + h * h;
  endfunction

  function automatic int l3_w_off(input int h);
    return 3 * h + h * h;
  endfunction

  function automatic int out_b_off(input int h);
    return 4 * h + h * h;
  endfunction

  function automatic int depth_of(input int h);
    return h * h + 4 * h + 1;
  endfunction

  // Floor shift by frac, then clamp to the signed dw-bit range; caller keeps the low dw bits.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int frac, input int dw);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Bias-load / multiply-accumulate / requantise datapath; acc updates one cycle after load or mac_en.
// No backpressure: the controller sequences every operation.
module mlp_mac
  import nn_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          mac_en,
  input  logic [DW-1:0] bias,
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] res
);

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [2*DW-1:0] prod;

  always_comb begin
    prod  = $signed(w) * $signed(x);
    acc_d = acc_q;
    if (load) begin
      acc_d = AW'($signed(bias)) <<< FRAC;
    end else if (mac_en) begin
      acc_d = acc_q + AW'(prod);
    end
    res = DW'(requant(64'(acc_q), FRAC, DW));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mlp_engine.sv
// Sequential 1->H->H->1 MLP inference, one product per cycle; done H*H+4H+2 cycles after accept.
// start is only accepted in IDLE (dropped otherwise); parameter writes are ignored while busy.
module mlp_engine
  import nn_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int H    = 16,
  parameter int AW   = 40,
  localparam int DEPTH = H * H + 4 * H + 1,
  localparam int ADW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [ADW-1:0] wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           start,
  input  logic [DW-1:0]  in_data,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  out_data
);

  localparam int NW = (H > 1) ? $clog2(H) : 1;
  localparam int SW = $clog2(H + 2);

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [SW-1:0]   step_q, step_d;
  logic [DW-1:0]   in_q, in_d;
  logic [DW-1:0]   out_q, out_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [DW-1:0]   param_mem [DEPTH];
  logic [DW-1:0]   act1 [H];
  logic [DW-1:0]   act2 [H];

  logic [ADW-1:0]  rd_addr;
  logic [NW-1:0]   k;
  logic            mac_load, mac_en;
  logic [DW-1:0]   mac_x, mac_res;
  logic            a1_we, a2_we;
  logic [NW-1:0]   a_idx;
  logic [DW-1:0]   a_dat;

  mlp_mac #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mac_load),
    .mac_en (mac_en),
    .bias   (param_mem[rd_addr]),
    .w      (param_mem[rd_addr]),
    .x      (mac_x),
    .res    (mac_res)
  );

  // A neuron's result is written back during the bias-load cycle of the next
  // neuron, while the accumulator still holds the finished sum.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    step_d   = step_q;
    in_d     = in_q;
    out_d    = out_q;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    rd_addr  = '0;
    mac_x    = in_q;
    k        = NW'(step_q - SW'(1));
    a1_we    = 1'b0;
    a2_we    = 1'b0;
    a_idx    = NW'(n_q - NW'(1));
    a_dat    = mac_res[DW-1] ? '0 : mac_res;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = in_data;
          state_d = S_L1;
          n_d     = '0;
          step_d  = '0;
        end
      end
      S_L1: begin
        if (step_q == '0) begin
          mac_load = 1'b1;
          rd_addr  = ADW'(l1_b_off(H) + int'(n_q));
          a1_we    = (n_q != '0);
          step_d   = SW'(1);
        end else begin
          mac_en  = 1'b1;
          rd_addr = ADW'(int'(n_q));
          step_d  = '0;
          if (n_q == NW'(H - 1)) begin
            n_d     = '0;
            state_d = S_L2;
          end else begin
            n_d = n_q + NW'(1);
          end
        end
      end
      S_L2: begin
        if (step_q == '0) begin
          mac_load = 1'b1;
          rd_addr  = ADW'(l2_b_off(H) + int'(n_q));
          if (n_q == '0) begin
            a1_we = 1'b1;
            a_idx = NW'(H - 1);
          end else begin
            a2_we = 1'b1;
          end
          step_d = SW'(1);
        end else begin
          mac_en  = 1'b1;
          rd_addr = ADW'(l2_w_off(H) + int'(n_q) * H + int'(k));
          mac_x   = act1[k];
          if (step_q == SW'(H)) begin
            step_d = '0;
            if (n_q == NW'(H - 1)) begin
              n_d     = '0;
              state_d = S_L3;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
      end
      S_L3: begin
        if (step_q == '0) begin
          mac_load = 1'b1;
          rd_addr  = ADW'(out_b_off(H));
          a2_we    = 1'b1;
          a_idx    = NW'(H - 1);
          step_d   = SW'(1);
        end else if (step_q == SW'(H + 1)) begin
          out_d   = mac_res;
          state_d = S_DONE;
        end else begin
          mac_en  = 1'b1;
          rd_addr = ADW'(l3_w_off(H) + int'(k));
          mac_x   = act2[k];
          step_d  = step_q + SW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      step_q  <= '0;
      in_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      step_q  <= step_d;
      in_q    <= in_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Parameters and activations deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && ({1'b0, wr_addr} < (ADW + 1)'(DEPTH))) begin
      param_mem[wr_addr] <= wr_data;
    end
    if (a1_we) act1[a_idx] <= a_dat;
    if (a2_we) act2[a_idx] <= a_dat;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_q;

endmodule

// File: tb/tb_mlp_engine.sv
// Directed bench for mlp_engine with H=4: map, latency, ReLU, saturation, busy lockout, reset abort, back-to-back.
module tb_mlp_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic [15:0] out_data;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  mlp_engine #(.DW(16), .FRAC(8), .H(4), .AW(40)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .out_data (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [15:0] dat);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_data = dat;
    tick();
    wr_en   = 1'b0;
  endtask

  // Map for H=4: biases at 4..7, 24..27, 32; all other words are weights.
  function automatic bit is_bias(input int a);
    return (a >= 4 && a < 8) || (a >= 24 && a < 28) || (a == 32);
  endfunction

  task automatic identity_setup();
    for (int a = 0; a < 33; a++) wr(a, 16'h0000);
    wr(0, 16'h0100);
    wr(8, 16'h0100);
    wr(28, 16'h0100);
  endtask

  task automatic run_inf(input logic [15:0] x, output logic [15:0] res, output int lat);
    int t0;
    start   = 1'b1;
    in_data = x;
    tick();
    t0    = cyc;
    start = 1'b0;
    lat   = -1;
    res   = 16'hxxxx;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) begin
        lat = cyc - t0;
        res = out_data;
        break;
      end
    end
    tick();
  endtask

  initial begin
    logic [15:0] res;
    int          lat;
    int          t0;
    int          ndone;
    int          dt[3];
    logic [15:0] ov[3];

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; in_data = '0;
    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // Only the output bias set: result is that bias.
    for (int a = 0; a < 33; a++) wr(a, 16'h0000);
    wr(32, 16'h0100);
    run_inf(16'h1234, res, lat);
    chk("bias_only_out", 32'(res), 32'h0100);
    chk("bias_only_lat", 32'(lat), 32'd34);

    identity_setup();
    run_inf(16'h0280, res, lat);
    chk("ident_pos_out", 32'(res), 32'h0280);
    chk("ident_pos_lat", 32'(lat), 32'd34);
    run_inf(16'hFD80, res, lat);
    chk("ident_neg_relu", 32'(res), 32'h0000);
    chk("ident_neg_lat", 32'(lat), 32'd34);

    for (int a = 0; a < 33; a++) wr(a, is_bias(a) ? 16'h0000 : 16'h7FFF);
    run_inf(16'h7FFF, res, lat);
    chk("sat_pos_out", 32'(res), 32'h7FFF);
    for (int a = 28; a < 32; a++) wr(a, 16'h8000);
    run_inf(16'h7FFF, res, lat);
    chk("sat_neg_out", 32'(res), 32'h8000);

    // Start and parameter write while busy must both be dropped.
    identity_setup();
    start = 1'b1; in_data = 16'h0280;
    tick();
    t0 = cyc; start = 1'b0; ndone = 0; lat = -1; res = 16'hxxxx;
    for (int i = 1; i <= 50; i++) begin
      if (i == 5) begin
        start = 1'b1; in_data = 16'h0500; wr_en = 1'b1; wr_addr = 6'd28; wr_data = 16'h0000;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc - t0;
          res = out_data;
        end
      end
    end
    start = 1'b0; wr_en = 1'b0;
    chk("busy_lock_ndone", 32'(ndone), 32'd1);
    chk("busy_lock_lat", 32'(lat), 32'd34);
    chk("busy_lock_out", 32'(res), 32'h0280);
    run_inf(16'h0280, res, lat);
    chk("busy_lock_wr_ignored", 32'(res), 32'h0280);

    // Reset ten cycles into L2.
    start = 1'b1; in_data = 16'h0280;
    tick();
    start = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", 32'(out_data), 32'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_inf(16'h0280, res, lat);
    chk("abort_restart_out", 32'(res), 32'h0280);
    chk("abort_restart_lat", 32'(lat), 32'd34);

    // start held high: back-to-back accepts 36 cycles apart.
    start = 1'b1; in_data = 16'h0280;
    tick();
    t0 = cyc; ndone = 0;
    for (int j = 0; j < 3; j++) begin
      dt[j] = -1000;
      ov[j] = 16'hxxxx;
    end
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (done) begin
        if (ndone < 3) begin
          dt[ndone] = cyc - t0;
          ov[ndone] = out_data;
        end
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_first_lat", 32'(dt[0]), 32'd34);
    chk("b2b_gap1", 32'(dt[1] - dt[0]), 32'd36);
    chk("b2b_gap2", 32'(dt[2] - dt[1]), 32'd36);
    chk("b2b_out0", 32'(ov[0]), 32'h0280);
    chk("b2b_out1", 32'(ov[1]), 32'h0280);
    chk("b2b_out2", 32'(ov[2]), 32'h0280);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
